// File: rtl/mecobo_cmd_pkg.sv
// Shared command-word layout, scheduler state encoding and opcode values
// used by the command scheduler and the pin/DAC target controllers.
package mecobo_cmd_pkg;

    localparam int CMD_WIDTH = 80;

    localparam int START_HI   = 79;
    localparam int START_LO   = 48;
    localparam int TARGET_HI  = 47;
    localparam int TARGET_LO  = 40;
    localparam int OPCODE_HI  = 39;
    localparam int OPCODE_LO  = 32;
    localparam int PAYLOAD_HI = 31;
    localparam int PAYLOAD_LO = 0;

    localparam int START_W   = START_HI - START_LO + 1;
    localparam int TARGET_W  = TARGET_HI - TARGET_LO + 1;
    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
    localparam int PAYLOAD_W = PAYLOAD_HI - PAYLOAD_LO + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_FLUSH = 3'd4
    } sched_state_e;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_PIN   = 8'h01;
    localparam logic [7:0] OP_CLR_PIN   = 8'h02;
    localparam logic [7:0] OP_DAC_WRITE = 8'h03;
    localparam logic [7:0] OP_PWM       = 8'h04;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmd_scheduler.sv
// Pops timed commands from the host command FIFO, holds each until global_clock
// reaches its start time, then hands it to one target controller.
module cmd_scheduler
    import mecobo_cmd_pkg::*;
#(
    parameter int NUM_TARGETS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            global_clock,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [CMD_WIDTH-1:0]   cmd_fifo_data_out,
    input  logic                   cmd_fifo_empty,
    output logic                   cmd_fifo_rd_en,
    output logic [NUM_TARGETS-1:0] tgt_valid,
    input  logic [NUM_TARGETS-1:0] tgt_ready,
    output logic [7:0]             tgt_opcode,
    output logic [31:0]            tgt_payload,
    output logic                   busy,
    output logic [15:0]            late_count,
    output logic [15:0]            drop_count
);

    // Handshake: a target accepts on the cycle tgt_valid[i] & tgt_ready[i];
    // valid and both buses stay stable until then, apart from flush or reset.
    sched_state_e            state_q, state_d;
    logic [START_W-1:0]      start_q, start_d;
    logic [TARGET_W-1:0]     target_q, target_d;
    logic [OPCODE_W-1:0]     opcode_q, opcode_d;
    logic [PAYLOAD_W-1:0]    payload_q, payload_d;
    logic [NUM_TARGETS-1:0]  valid_q, valid_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [15:0]             late_q, late_d;
    logic [15:0]             drop_q, drop_d;
    logic                    rd_en_c;
    logic                    due;
    logic                    handshake;

    // Wrap-aware: due once global_clock is at or past start_time modulo 2^32.
    assign due       = (start_q == '0) || ($signed(global_clock - start_q) >= 0);
    assign handshake = |(valid_q & tgt_ready);

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        target_d  = target_q;
        opcode_d  = opcode_q;
        payload_d = payload_q;
        valid_d   = valid_q;
        late_d    = late_q;
        drop_d    = drop_q;
        rd_en_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (enable && !cmd_fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                start_d   = cmd_fifo_data_out[START_HI:START_LO];
                target_d  = cmd_fifo_data_out[TARGET_HI:TARGET_LO];
                opcode_d  = cmd_fifo_data_out[OPCODE_HI:OPCODE_LO];
                payload_d = cmd_fifo_data_out[PAYLOAD_HI:PAYLOAD_LO];
                if (flush) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = ST_FLUSH;
                end else if (int'(cmd_fifo_data_out[TARGET_HI:TARGET_LO]) >= NUM_TARGETS) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = ST_FLUSH;
                end else if (due) begin
                    for (int i = 0; i < NUM_TARGETS; i++) begin
                        valid_d[i] = (int'(target_q) == i);
                    end
                    if (start_q != '0 && global_clock != start_q) begin
                        late_d = sat_inc(late_q);
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A flush coinciding with acceptance still lets the target have it.
                if (flush) begin
                    valid_d = '0;
                    if (!handshake) begin
                        drop_d = sat_inc(drop_q);
                    end
                    state_d = ST_FLUSH;
                end else if (handshake) begin
                    valid_d = '0;
                    if (enable && !cmd_fifo_empty) begin
                        rd_en_c = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (!cmd_fifo_empty) begin
                    rd_en_c = 1'b1;
                    drop_d  = sat_inc(drop_q);
                end else if (!rd_pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        rd_pend_d = rd_en_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            target_q  <= '0;
            opcode_q  <= '0;
            payload_q <= '0;
            valid_q   <= '0;
            rd_pend_q <= 1'b0;
            late_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            target_q  <= target_d;
            opcode_q  <= opcode_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            rd_pend_q <= rd_pend_d;
            late_q    <= late_d;
            drop_q    <= drop_d;
        end
    end

    assign cmd_fifo_rd_en = rd_en_c & ~rst;
    assign tgt_valid      = valid_q;
    assign tgt_opcode     = opcode_q;
    assign tgt_payload    = payload_q;
    assign busy           = (state_q != ST_IDLE);
    assign late_count     = late_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: FIFO model, issue scoreboard, vector table and
// hand-written flush / backpressure / reset sequences.
module tb_cmd_scheduler;
    import mecobo_cmd_pkg::*;

    localparam int NT = 8;

    logic          clk;
    logic          rst;
    logic [31:0]   gc;
    bit            gc_run;
    logic          enable;
    logic          flush;
    logic [79:0]   fifo_dout;
    logic          fifo_empty;
    logic          rd_en;
    logic [NT-1:0] tgt_valid;
    logic [NT-1:0] tgt_ready;
    logic [7:0]    tgt_opcode;
    logic [31:0]   tgt_payload;
    logic          busy;
    logic [15:0]   late_count;
    logic [15:0]   drop_count;

    int errors = 0;
    int checks = 0;

    logic [79:0] fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [47:0] exp_q[$];

    cmd_scheduler #(.NUM_TARGETS(NT)) dut (
        .clk               (clk),
        .rst               (rst),
        .global_clock      (gc),
        .enable            (enable),
        .flush             (flush),
        .cmd_fifo_data_out (fifo_dout),
        .cmd_fifo_empty    (fifo_empty),
        .cmd_fifo_rd_en    (rd_en),
        .tgt_valid         (tgt_valid),
        .tgt_ready         (tgt_ready),
        .tgt_opcode        (tgt_opcode),
        .tgt_payload       (tgt_payload),
        .busy              (busy),
        .late_count        (late_count),
        .drop_count        (drop_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model (data valid the cycle after rd_en) ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en) begin
            checks++;
            if (wr_ptr == rd_ptr) begin
                errors++;
                $display("FAIL pop_when_empty: got rd_en=1, expected 0 with FIFO empty");
            end else begin
                fifo_dout <= fifo_mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [47:0] mon_exp;
    logic [47:0] mon_got;
    logic [7:0]  mon_idx;
    logic        hold_prev = 1'b0;
    logic [NT-1:0] hold_valid;
    logic [7:0]  hold_op;
    logic [31:0] hold_pay;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            checks++;
            if (!$onehot0(tgt_valid)) begin
                errors++;
                $display("FAIL onehot: got tgt_valid=%b, expected at most one bit", tgt_valid);
            end
            if (hold_prev && tgt_valid != '0) begin
                checks++;
                if ({tgt_valid, tgt_opcode, tgt_payload} !== {hold_valid, hold_op, hold_pay}) begin
                    errors++;
                    $display("FAIL stable: got %h/%h/%h, expected %h/%h/%h",
                             tgt_valid, tgt_opcode, tgt_payload, hold_valid, hold_op, hold_pay);
                end
            end
            if (|(tgt_valid & tgt_ready)) begin
                checks++;
                mon_idx = 8'd0;
                for (int i = 0; i < NT; i++) begin
                    if (tgt_valid[i]) mon_idx = 8'(i);
                end
                mon_got = {mon_idx, tgt_opcode, tgt_payload};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got %h, expected no issue", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL issue: got %h, expected %h", mon_got, mon_exp);
                    end
                end
            end
            hold_prev  = (tgt_valid != '0) && !(|(tgt_valid & tgt_ready));
            hold_valid = tgt_valid;
            hold_op    = tgt_opcode;
            hold_pay   = tgt_payload;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        if (gc_run) gc = gc + 32'd1;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] st, input logic [7:0] tg,
                            input logic [7:0] op, input logic [31:0] pl, input bit expect_issue);
        fifo_mem[wr_ptr % 256] = {st, tg, op, pl};
        wr_ptr = wr_ptr + 1;
        if (expect_issue) exp_q.push_back({tg, op, pl});
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && busy; k++) cyc();
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid(input int bound);
        for (int k = 0; k < bound && tgt_valid == '0; k++) cyc();
        chk("valid_timeout", tgt_valid != '0, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] start_time;
        logic [7:0]  target;
        logic [7:0]  opcode;
        logic [31:0] payload;
        logic [31:0] gc_init;
        bit          gc_run;
        int          exp_lat;   // rd_en cycle to tgt_valid rise; 0 = never
        int          exp_late;  // cumulative
        int          exp_drop;  // cumulative
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v);
        int lat;
        bit seen;
        gc        = v.gc_init;
        gc_run    = v.gc_run;
        tgt_ready = '1;
        push_cmd(v.start_time, v.target, v.opcode, v.payload, int'(v.target) < NT);
        enable = 1'b1;
        #1;
        chk("vec_rd_en", rd_en, 1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            cyc();
            if (tgt_valid != '0) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (v.exp_lat == 0) chk("vec_no_valid", seen, 0);
        else                chk("vec_latency", lat, v.exp_lat);
        wait_idle(50);
        chk("vec_late_count", late_count, v.exp_late);
        chk("vec_drop_count", drop_count, v.exp_drop);
        enable = 1'b0;
        gc_run = 1'b0;
    endtask

    // ---------------- main test ----------------
    int          rise [4];
    int          nrise;
    bit          prev_v;
    bit          seen_v;
    logic [31:0] pay;

    initial begin
        rst       = 1'b1;
        gc        = '0;
        gc_run    = 1'b0;
        enable    = 1'b1;
        flush     = 1'b0;
        tgt_ready = '1;
        fifo_dout = '0;

        vecs[0] = '{32'd0,        8'd3, OP_SET_PIN,   32'hCAFEBABE, 32'd0,        1'b0, 3,  0, 0};
        vecs[1] = '{32'd100,      8'd5, OP_CLR_PIN,   32'h12345678, 32'd90,       1'b1, 11, 0, 0};
        vecs[2] = '{32'd100,      8'd1, OP_DAC_WRITE, 32'h0000BEEF, 32'd150,      1'b0, 3,  1, 0};
        vecs[3] = '{32'd0,        8'd9, OP_PWM,       32'hDEADBEEF, 32'd0,        1'b0, 0,  1, 1};
        vecs[4] = '{32'd200,      8'd6, OP_SET_PIN,   32'hA5A5A5A5, 32'd200,      1'b0, 3,  1, 1};
        vecs[5] = '{32'd50,       8'd2, OP_CLR_PIN,   32'h0F0F0F0F, 32'd40,       1'b1, 11, 1, 1};
        vecs[6] = '{32'd10,       8'd4, OP_DAC_WRITE, 32'h11112222, 32'd9,        1'b1, 3,  2, 1};
        vecs[7] = '{32'd0,        8'd7, OP_PWM,       32'h33334444, 32'd0,        1'b0, 3,  2, 1};
        vecs[8] = '{32'd0,        8'd8, OP_SET_PIN,   32'h55556666, 32'd0,        1'b0, 0,  2, 2};
        vecs[9] = '{32'h00000005, 8'd0, OP_CLR_PIN,   32'h77778888, 32'hFFFFFFFA, 1'b1, 12, 2, 2};

        // Reset values, with a command waiting and enable high.
        push_cmd(32'd0, 8'd0, OP_NOP, $urandom, 1'b1);
        cyc();
        cyc();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", tgt_valid, 0);
        chk("rst_opcode", tgt_opcode, 0);
        chk("rst_payload", tgt_payload, 0);
        chk("rst_busy", busy, 0);
        chk("rst_late", late_count, 0);
        chk("rst_drop", drop_count, 0);
        rst = 1'b0;
        wait_valid(10);
        wait_idle(10);
        enable = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Backpressure: only the selected target withholds ready.
        gc        = '0;
        tgt_ready = 8'hFB;
        pay       = $urandom;
        push_cmd(32'd0, 8'd2, 8'h55, pay, 1'b1);
        enable = 1'b1;
        wait_valid(10);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("bp_valid", tgt_valid, 8'h04);
            chk("bp_opcode", tgt_opcode, 8'h55);
            chk("bp_payload", tgt_payload, pay);
        end
        tgt_ready = '1;
        cyc();
        chk("bp_valid_drop", tgt_valid, 0);
        enable = 1'b0;
        wait_idle(10);

        // Back-to-back: four queued immediate commands.
        for (int i = 0; i < 4; i++) push_cmd(32'd0, 8'(i), 8'(8'h10 + i), $urandom, 1'b1);
        enable = 1'b1;
        #1;
        chk("b2b_rd_en", rd_en, 1);
        nrise  = 0;
        prev_v = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (tgt_valid != '0 && !prev_v && nrise < 4) begin
                rise[nrise] = c;
                nrise++;
            end
            prev_v = (tgt_valid != '0);
        end
        chk("b2b_count", nrise, 4);
        for (int i = 0; i < 4; i++) chk("b2b_rise", rise[i], 3 * (i + 1));
        enable = 1'b0;
        wait_idle(10);

        // Flush while a future command waits and three more are queued.
        gc = '0;
        push_cmd(32'd1000, 8'd1, OP_SET_PIN, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) push_cmd(32'd0, 8'd3, OP_PWM, $urandom, 1'b0);
        enable = 1'b1;
        #1;
        chk("fl_rd_en", rd_en, 1);
        cyc();
        enable = 1'b0;
        seen_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (tgt_valid != '0) seen_v = 1'b1;
        end
        chk("fl_busy_wait", busy, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 20 && busy; k++) begin
            cyc();
            if (tgt_valid != '0) seen_v = 1'b1;
        end
        chk("fl_idle", busy, 0);
        chk("fl_no_valid", seen_v, 0);
        chk("fl_drained", wr_ptr - rd_ptr, 0);
        chk("fl_drop", drop_count, 6);
        chk("fl_late", late_count, 2);

        // Flush in the same cycle as acceptance: issued, not dropped.
        tgt_ready = '0;
        push_cmd(32'd0, 8'd4, OP_DAC_WRITE, 32'h0BADF00D, 1'b1);
        enable = 1'b1;
        wait_valid(10);
        enable = 1'b0;
        cyc();
        cyc();
        tgt_ready = '1;
        flush     = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fh_valid", tgt_valid, 0);
        wait_idle(10);
        chk("fh_drop", drop_count, 6);

        // Reset during ISSUE with another command queued.
        tgt_ready = '0;
        push_cmd(32'd0, 8'd6, OP_PWM, 32'h600DCAFE, 1'b1);
        enable = 1'b1;
        wait_valid(10);
        push_cmd(32'd0, 8'd0, OP_SET_PIN, 32'h0000ABCD, 1'b0);
        rst = 1'b1;
        #1;
        chk("ri_valid", tgt_valid, 0);
        chk("ri_opcode", tgt_opcode, 0);
        chk("ri_payload", tgt_payload, 0);
        chk("ri_busy", busy, 0);
        chk("ri_rd_en", rd_en, 0);
        chk("ri_late", late_count, 0);
        chk("ri_drop", drop_count, 0);
        exp_q.delete();
        cyc();
        tgt_ready = '1;
        exp_q.push_back({8'd0, OP_SET_PIN, 32'h0000ABCD});
        rst = 1'b0;
        wait_valid(10);
        wait_idle(10);
        chk("ri_counts", {late_count, drop_count}, 0);
        enable = 1'b0;
        cyc();
        cyc();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
